muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the single-cycle ALU in the MIPS datapath and executes MULT, MULTU, DIV and DIVU over multiple cycles. It also services MFHI/MFLO reads and MTHI/MTLO writes. The controller stalls dependent HI/LO reads while `busy` is high.

## Interface
- WIDTH, 32, operand/result width in bits; ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled on the clk edge only when idle.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (rs); sampled with start.
- b  in  WIDTH  multiplier / divisor (rt); sampled with start.
- we_hi  in  1  MTHI: write wd into hi.
- we_lo  in  1  MTLO: write wd into lo.
- wd  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo hold a fresh result.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM states:
  - IDLE –start→ RUN.
  - RUN –count==WIDTH-1→ FIX.
  - FIX → IDLE (unconditional).
- IDLE, start=1 at an edge:
  - latch op, |a|, |b|, and the sign flags (signed ops only);
  - count := 0.
- RUN: one radix-2 iteration per cycle, WIDTH cycles in total.
  - Multiply: shift-add into a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract; WIDTH+1-bit partial remainder, quotient shifted into the low half.
- FIX:
  - Sign-correct the magnitudes. Product is negated when sign(a)≠sign(b). Quotient is negated when sign(a)≠sign(b). Remainder takes the sign of a.
  - Write hi/lo.
- Division rounds toward zero. The most-negative value divided by −1 gives lo = most-negative, hi = 0; no trap.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = a as latched (original signed value), regardless of sign.
- MTHI/MTLO:
  - In IDLE, we_hi / we_lo update hi / lo at the edge.
  - While busy (RUN/FIX), the writes are dropped.
  - A write in the same cycle as an accepted start is applied; the result later overwrites it.
- start while busy: ignored. No queueing, latched operands are unchanged.
- hi/lo change only at: reset, the FIX edge, or an accepted MTHI/MTLO.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, count=0.
- Reset asserted mid-operation aborts immediately. hi/lo are cleared, not written with a partial result. No done pulse.
- Start accepted at edge E0:
  - busy=1 from E0 until edge E0+WIDTH+1;
  - hi/lo written at edge E0+WIDTH+1;
  - done=1 for exactly one cycle after that edge;
  - busy=0 from that same edge.
- Latency is WIDTH+1 cycles from the start edge to a valid result. Occupancy is the same; there is no pipelining.
- Back-to-back operation: start asserted while done=1 is accepted. The next result is ready WIDTH+1 cycles later.
- hi/lo are registered outputs. MFHI/MFLO see the new value in the cycle done is high.
- busy and done are registered, with no combinational path from any input.

## Test plan
1. MULTU, a=b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses for one cycle, busy was high for exactly 33 cycles.
2. MULT, a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIVU, a=100, b=7 → lo=14, hi=2.
3. DIV, a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIV, a=−5, b=0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB. DIVU, a=9, b=0 → lo=0xFFFFFFFF, hi=9.
5. start MULTU 2×3, then on cycle 5 pulse start (DIVU) and we_hi with wd=0x1234 → both ignored; result hi=0, lo=6; done pulses only once.
6. In IDLE, we_lo with wd=0xA5A5 → lo=0xA5A5 next cycle. Then start MULT, assert reset on cycle 10 → busy=0, hi=lo=0, no done; a new start after reset completes correctly. Repeat test 1 with WIDTH=8: result after 9 cycles (hi=0xFE, lo=0x01).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset, start/op/a/b request, we_hi/we_lo/wd MTHI/MTLO, busy/done/hi/lo.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  // operand capture (op[0]=0 selects signed ops)
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;

  // one iteration of each datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_acc;

  // sign fix-up
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    sa = ~op[0] & a[WIDTH-1];
    sb = ~op[0] & b[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // restoring step: the shifted remainder is below
    // 2*mag_b, so the difference always fits WIDTH bits
    div_sh   = {rem, acc[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, mag_b};
    div_rem  = div_ge ? div_sh[WIDTH-1:0] - mag_b
                      : div_sh[WIDTH-1:0];
    div_acc  = {acc[2*WIDTH-1:WIDTH],
                acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    neg    = sign_a ^ sign_b;
    prod   = neg ? -acc : acc;
    quo    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd    = sign_a ? -rem : rem;
    // re-signing |a| recovers the original dividend,
    // including the most-negative value
    a_orig = sign_a ? -mag_a : mag_a;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (mag_b == '0) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_hi = rmd;
        fix_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (we_hi) hi <= wd;
          if (we_lo) lo <= wd;
          if (start) begin
            op_q   <= op;
            sign_a <= sa;
            sign_b <= sb;
            mag_a  <= ma;
            mag_b  <= mb;
            // low half: multiplier or dividend
            acc    <= op[1] ? {{WIDTH{1'b0}}, ma}
                            : {{WIDTH{1'b0}}, mb};
            rem    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (op_q[1]) begin
            acc <= div_acc;
            rem <= div_rem;
          end else begin
            acc <= mul_next;
          end
          count <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Covers WIDTH=32 ops, MTHI/MTLO, busy drop, reset abort, WIDTH=8.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        we_hi8;
  logic        we_lo8;
  logic [7:0]  wd8;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int checks;
  int failures;
  int n;
  int pulses;
  int busy_seen;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .op    (op8),
    .a     (a8),
    .b     (b8),
    .we_hi (we_hi8),
    .we_lo (we_lo8),
    .wd    (wd8),
    .busy  (busy8),
    .done  (done8),
    .hi    (hi8),
    .lo    (lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // caller sits at a negedge; start is sampled
  // at the following posedge
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y);
    int c;
    issue(o, x, y);
    wait_done(c);
    chk({tag, "_busycyc"}, c, 33);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    a        = '0;
    b        = '0;
    we_hi    = 1'b0;
    we_lo    = 1'b0;
    wd       = '0;
    start8   = 1'b0;
    op8      = 2'd0;
    a8       = '0;
    b8       = '0;
    we_hi8   = 1'b0;
    we_lo8   = 1'b0;
    wd8      = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MULTU max*max
    run("multu_max", 2'd1, 32'hFFFF_FFFF,
        32'hFFFF_FFFF);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("multu_max_done_drop", done, 0);

    // 2: MULT -3*5, then DIVU back-to-back
    run("mult_neg", 2'd0, -32'sd3, 32'd5);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run("divu", 2'd3, 32'd100, 32'd7);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // 3: signed division and overflow case
    run("div_neg", 2'd2, -32'sd7, 32'd2);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run("div_pn", 2'd2, 32'd7, -32'sd2);
    chk("div_pn_lo", lo, 32'hFFFF_FFFD);
    chk("div_pn_hi", hi, 32'd1);
    run("div_ovf", 2'd2, 32'h8000_0000,
        32'hFFFF_FFFF);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // 4: divide by zero
    run("div_z", 2'd2, -32'sd5, 32'd0);
    chk("div_z_lo", lo, 32'hFFFF_FFFF);
    chk("div_z_hi", hi, 32'hFFFF_FFFB);
    run("divu_z", 2'd3, 32'd9, 32'd0);
    chk("divu_z_lo", lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", hi, 32'd9);
    @(negedge clk);

    // 5: start and MTHI while busy are dropped
    issue(2'd1, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd100;
    b     = 32'd7;
    we_hi = 1'b1;
    wd    = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    we_hi = 1'b0;
    chk("busy_mthi_drop", hi, 32'd9);
    pulses = 0;
    wait_done(n);
    chk("busy_ign_wait", n < 200, 1);
    if (done) pulses++;
    chk("busy_ign_hi", hi, 32'd0);
    chk("busy_ign_lo", lo, 32'd6);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    chk("busy_ign_pulses", pulses, 1);
    chk("busy_ign_noqueue", busy_seen, 0);

    // 6: MTLO in idle, then reset mid-operation
    we_lo = 1'b1;
    wd    = 32'hA5A5;
    @(negedge clk);
    we_lo = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5);
    chk("mtlo_hi", hi, 32'd0);
    issue(2'd0, 32'd7, -32'sd2);
    repeat (8) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    run("post_rst", 2'd0, 32'd7, -32'sd2);
    chk("post_rst_hi", hi, 32'hFFFF_FFFF);
    chk("post_rst_lo", lo, 32'hFFFF_FFF2);
    @(negedge clk);

    // WIDTH=8 MULTU max*max
    start8 = 1'b1;
    op8    = 2'd1;
    a8     = 8'hFF;
    b8     = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("w8_busycyc", n, 9);
    chk("w8_done", done8, 1);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
